// File: rtl/button_event_ctrl.sv
// Gesture classifier for the debounced encoder pushbutton and slide switch.
// Button activity becomes SINGLE / DOUBLE / LONG events and switch edges
// become SWT_ON / SWT_OFF events. Each event is presented through a one-entry
// valid/ack holding register with a sticky overflow flag.
module button_event_ctrl #(
    parameter int CLOCK_FREQ_HZ    = 100000000,
    parameter int TICK_HZ          = 1000,
    parameter int LONG_PRESS_TICKS = 1000,
    parameter int DCLICK_TICKS     = 300,
    parameter int SIMULATE         = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       btn_db,
    input  logic       swt_db,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    input  logic       evt_ack,
    output logic       evt_overflow,
    output logic [2:0] state_dbg
);

    localparam int unsigned PERIOD = (SIMULATE != 0) ? 5 : (CLOCK_FREQ_HZ / TICK_HZ - 1);
    localparam int          CW     = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);

    localparam logic [15:0] LONG_LAST   = 16'(LONG_PRESS_TICKS - 1);
    localparam logic [15:0] DCLICK_LAST = 16'(DCLICK_TICKS - 1);

    localparam logic [2:0] EVT_NONE    = 3'd0;
    localparam logic [2:0] EVT_SINGLE  = 3'd1;
    localparam logic [2:0] EVT_DOUBLE  = 3'd2;
    localparam logic [2:0] EVT_LONG    = 3'd3;
    localparam logic [2:0] EVT_SWT_ON  = 3'd4;
    localparam logic [2:0] EVT_SWT_OFF = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } state_t;

    state_t      state;
    logic [CW-1:0] tick_cnt;
    logic        tick;
    logic [15:0] tcnt;
    logic        btn_d, swt_d;
    logic        btn_rise, btn_fall, swt_rise, swt_fall;
    logic [2:0]  btn_code, swt_code, new_code;
    logic        new_evt, collide, accept;

    assign tick      = (tick_cnt == CW'(PERIOD));
    assign btn_rise  = btn_db & ~btn_d;
    assign btn_fall  = ~btn_db & btn_d;
    assign swt_rise  = swt_db & ~swt_d;
    assign swt_fall  = ~swt_db & swt_d;
    assign state_dbg = state;

    // Free-running timebase: one-clock tick when the counter hits the period
    always_ff @(posedge clk) begin
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // Delayed copies of the inputs for edge detection; switch preloads so a
    // switch already high at reset does not look like a rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_d <= 1'b0;
            swt_d <= swt_db;
        end else begin
            btn_d <= btn_db;
            swt_d <= swt_db;
        end
    end

    // Button event decode; in WAIT2 a press beats a simultaneous timeout
    always_comb begin
        btn_code = EVT_NONE;
        if (en) begin
            case (state)
                PRESS1:  if (!btn_fall && tick && tcnt == LONG_LAST)   btn_code = EVT_LONG;
                WAIT2:   if (!btn_rise && tick && tcnt == DCLICK_LAST) btn_code = EVT_SINGLE;
                PRESS2:  if (btn_fall)                                 btn_code = EVT_DOUBLE;
                default: btn_code = EVT_NONE;
            endcase
        end
    end

    // Switch edges become events regardless of the classifier enable
    always_comb begin
        swt_code = EVT_NONE;
        if (swt_rise)      swt_code = EVT_SWT_ON;
        else if (swt_fall) swt_code = EVT_SWT_OFF;
    end

    // Gesture FSM and tick counter; tcnt clears on every transition
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_rise) begin
                        state <= PRESS1;
                        tcnt  <= '0;
                    end
                end
                PRESS1: begin
                    if (btn_fall) begin
                        state <= WAIT2;
                        tcnt  <= '0;
                    end else if (btn_code == EVT_LONG) begin
                        state <= LONG_HELD;
                        tcnt  <= '0;
                    end else if (tick) begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                WAIT2: begin
                    if (btn_rise) begin
                        state <= PRESS2;
                        tcnt  <= '0;
                    end else if (btn_code == EVT_SINGLE) begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end else if (tick) begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                PRESS2: begin
                    if (btn_fall) begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end
                end
                LONG_HELD: begin
                    if (btn_fall) begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    assign new_evt  = (btn_code != EVT_NONE) || (swt_code != EVT_NONE);
    assign collide  = (btn_code != EVT_NONE) && (swt_code != EVT_NONE);
    assign new_code = (btn_code != EVT_NONE) ? btn_code : swt_code;
    assign accept   = evt_valid & evt_ack;

    // One-entry holding register; a busy slot drops newcomers and flags it
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid    <= 1'b0;
            evt_code     <= EVT_NONE;
            evt_overflow <= 1'b0;
        end else if (accept) begin
            if (new_evt) begin
                evt_valid    <= 1'b1;
                evt_code     <= new_code;
                evt_overflow <= collide;
            end else begin
                evt_valid    <= 1'b0;
                evt_code     <= EVT_NONE;
                evt_overflow <= 1'b0;
            end
        end else if (evt_valid) begin
            if (new_evt) evt_overflow <= 1'b1;
        end else if (new_evt) begin
            evt_valid    <= 1'b1;
            evt_code     <= new_code;
            evt_overflow <= evt_overflow | collide;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed gesture scenarios followed by random
// button/switch/ack/enable/reset activity, all compared every clock against a
// gesture-level reference model.
module tb_button_event_ctrl;

    localparam int LONG_T   = 10;
    localparam int DCLICK_T = 4;

    logic       clk = 1'b0;
    logic       reset, en, btn_db, swt_db, evt_ack;
    logic       evt_valid, evt_overflow;
    logic [2:0] evt_code, state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model state: timebase phase, gesture description, holding slot
    int   phase;
    int   presses;     // presses seen in the current gesture (0, 1 or 2)
    bit   held;        // button is down inside the current gesture
    bit   long_done;   // long press already reported, waiting for release
    int   ticks;       // ticks since the last gesture edge
    bit   p_btn, p_swt;
    bit   exp_valid, exp_ovf;
    int   exp_code;

    button_event_ctrl #(
        .CLOCK_FREQ_HZ(100000000), .TICK_HZ(1000),
        .LONG_PRESS_TICKS(LONG_T), .DCLICK_TICKS(DCLICK_T), .SIMULATE(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .btn_db(btn_db), .swt_db(swt_db),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ack(evt_ack),
        .evt_overflow(evt_overflow), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_state();
        if (long_done)         return 4;
        if (presses == 0)      return 0;
        if (presses == 2)      return 3;
        return held ? 1 : 2;
    endfunction

    task automatic clear_gesture();
        presses = 0; held = 0; long_done = 0; ticks = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        bit tk, rise, fall, srise, sfall, accept;
        int bevt, sevt, ncode;
        if (reset) begin
            phase = 0; clear_gesture();
            p_btn = 0; p_swt = swt_db;
            exp_valid = 0; exp_code = 0; exp_ovf = 0;
            return;
        end
        tk    = (phase == 5);
        phase = tk ? 0 : phase + 1;
        rise  = btn_db && !p_btn;  fall  = !btn_db && p_btn;
        srise = swt_db && !p_swt;  sfall = !swt_db && p_swt;
        bevt  = 0;
        if (!en) clear_gesture();
        else if (long_done) begin
            if (fall) clear_gesture();
        end else if (presses == 0) begin
            if (rise) begin presses = 1; held = 1; ticks = 0; end
        end else if (presses == 1 && held) begin
            if (fall) begin held = 0; ticks = 0; end
            else if (tk) begin
                ticks++;
                if (ticks == LONG_T) begin bevt = 3; long_done = 1; ticks = 0; end
            end
        end else if (presses == 1) begin
            if (rise) begin presses = 2; held = 1; end
            else if (tk) begin
                ticks++;
                if (ticks == DCLICK_T) begin bevt = 1; clear_gesture(); end
            end
        end else begin
            if (fall) begin bevt = 2; clear_gesture(); end
        end
        sevt   = srise ? 4 : (sfall ? 5 : 0);
        ncode  = (bevt != 0) ? bevt : sevt;
        accept = exp_valid && evt_ack;
        if (accept) begin
            if (ncode != 0) begin
                exp_code = ncode; exp_ovf = (bevt != 0 && sevt != 0);
            end else begin
                exp_valid = 0; exp_code = 0; exp_ovf = 0;
            end
        end else if (exp_valid) begin
            if (ncode != 0) exp_ovf = 1;
        end else if (ncode != 0) begin
            exp_valid = 1; exp_code = ncode;
            exp_ovf = exp_ovf | (bevt != 0 && sevt != 0);
        end
        p_btn = btn_db; p_swt = swt_db;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("evt_valid", 8'(evt_valid), 8'(exp_valid));
        check("evt_code", 8'(evt_code), 8'(exp_code));
        check("evt_overflow", 8'(evt_overflow), 8'(exp_ovf));
        check("state_dbg", 8'(state_dbg), 8'(exp_state()));
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic ack_once();
        evt_ack = 1; hold(1); evt_ack = 0;
    endtask

    initial begin
        bit found;
        int seg_len;
        reset = 1; en = 1; btn_db = 0; swt_db = 0; evt_ack = 0;
        hold(3);
        check("rst_valid", 8'(evt_valid), 8'd0);
        check("rst_state", 8'(state_dbg), 8'd0);
        reset = 0; hold(2);

        // Single click
        btn_db = 1; hold(18); btn_db = 0; hold(48);
        check("s1_valid", 8'(evt_valid), 8'd1);
        check("s1_code", 8'(evt_code), 8'd1);
        ack_once();
        check("s1_ack_valid", 8'(evt_valid), 8'd0);

        // Double click
        btn_db = 1; hold(12); btn_db = 0; hold(12);
        btn_db = 1; hold(12); btn_db = 0; hold(1);
        check("s2_valid", 8'(evt_valid), 8'd1);
        check("s2_code", 8'(evt_code), 8'd2);
        hold(36);
        check("s2_nosingle", 8'(evt_overflow), 8'd0);
        ack_once();

        // Long press
        btn_db = 1; hold(90);
        check("s3_code", 8'(evt_code), 8'd3);
        check("s3_state", 8'(state_dbg), 8'd4);
        btn_db = 0; hold(1);
        check("s3_state_rel", 8'(state_dbg), 8'd0);
        check("s3_ovf_rel", 8'(evt_overflow), 8'd0);
        ack_once();

        // Switch on then off without ack
        swt_db = 1; hold(1);
        check("s4_on", 8'(evt_code), 8'd4);
        hold(3); swt_db = 0; hold(1);
        check("s4_held", 8'(evt_code), 8'd4);
        check("s4_ovf", 8'(evt_overflow), 8'd1);
        ack_once();
        check("s4_ack_valid", 8'(evt_valid), 8'd0);
        check("s4_ack_ovf", 8'(evt_overflow), 8'd0);

        // Pending SWT_ON acked in the very cycle a SINGLE is emitted
        swt_db = 1; hold(1);
        btn_db = 1; hold(12); btn_db = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (presses == 1 && !held && phase == 5 && ticks == DCLICK_T - 1) begin
                found = 1;
                break;
            end
            hold(1);
        end
        check("s5_reach", 8'(found), 8'd1);
        ack_once();
        check("s5_valid", 8'(evt_valid), 8'd1);
        check("s5_code", 8'(evt_code), 8'd1);
        check("s5_ovf", 8'(evt_overflow), 8'd0);
        ack_once();

        // Reset while pressed, then disable during the double-click window
        btn_db = 1; hold(20);
        check("s6_press", 8'(state_dbg), 8'd1);
        reset = 1; hold(1);
        check("s6_rst_valid", 8'(evt_valid), 8'd0);
        check("s6_rst_code", 8'(evt_code), 8'd0);
        check("s6_rst_state", 8'(state_dbg), 8'd0);
        reset = 0; hold(1);
        btn_db = 0; hold(1);
        check("s6_rel_valid", 8'(evt_valid), 8'd0);
        en = 0; hold(60);
        check("s6_en_valid", 8'(evt_valid), 8'd0);
        check("s6_en_state", 8'(state_dbg), 8'd0);
        en = 1; hold(2);

        // Random activity against the model
        for (int s = 0; s < 70; s++) begin
            btn_db  = 1'($urandom % 2);
            en      = ($urandom % 8) != 0;
            seg_len = $urandom_range(1, 80);
            for (int c = 0; c < seg_len; c++) begin
                if ($urandom % 40 == 0) swt_db = ~swt_db;
                evt_ack = ($urandom % 4) == 0;
                reset   = ($urandom % 500) == 0;
                hold(1);
            end
        end
        reset = 0; evt_ack = 0;
        hold(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
